scan_ctl_n: RTL and testbench



---
 rtl/scan_ctl_n_pkg.sv | 22 ++
 rtl/scan_prescaler.sv | 28 ++
 rtl/scan_ctl_n.sv | 99 +++++++++
 tb/tb_scan_ctl_n.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctl_n_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scanners.
package scan_ctl_n_pkg;

   localparam int BIT_WIDTH4       = 4;
   localparam int DEFAULT_SCAN_DIV = 50000;
   localparam int MAX_DIGITS       = 8;

   typedef enum logic [1:0] {
      ADV_HOLD,
      ADV_STEP,
      ADV_WRAP
   } adv_t;

   // All-digits-off select pattern; callers slice the low num_digits bits.
   function automatic logic [MAX_DIGITS-1:0] ctl_off(input int num_digits);
      ctl_off = '0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < num_digits) ctl_off[i] = 1'b1;
      end
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divide-by-SCAN_DIV tick generator; tick is high on the last count of each period.
module scan_prescaler
   import scan_ctl_n_pkg::*;
#(
   parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(SCAN_DIV);

   logic [CW-1:0] count;

   assign tick = (count == CW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/scan_ctl_n.sv
// N-digit time-multiplexed display scanner with enable mask, leading-zero
// blanking and per-frame snapshots of the display value.
module scan_ctl_n
   import scan_ctl_n_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DIGIT_WIDTH = BIT_WIDTH4,
   parameter int SCAN_DIV    = DEFAULT_SCAN_DIV
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] display,
   input  logic [NUM_DIGITS-1:0]             digit_en,
   input  logic                              lz_en,
   output logic [NUM_DIGITS-1:0]             ctl,
   output logic [DIGIT_WIDTH-1:0]            out,
   output logic                              frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [MAX_DIGITS-1:0] OFF_ALL = ctl_off(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] CTL_OFF = OFF_ALL[NUM_DIGITS-1:0];

   logic                              tick;
   logic [IDX_W-1:0]                  idx;
   logic [IDX_W-1:0]                  next_idx;
   logic [IDX_W-1:0]                  cand;
   logic                              found;
   adv_t                              adv;
   logic [NUM_DIGITS*DIGIT_WIDTH-1:0] shadow;
   logic [NUM_DIGITS*DIGIT_WIDTH-1:0] frame_data;
   logic                              upper_zero;
   logic [NUM_DIGITS-1:0]             ctl_next;
   logic [DIGIT_WIDTH-1:0]            out_next;

   scan_prescaler #(
      .SCAN_DIV(SCAN_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   // Walk upward from idx+1 (wrapping) to the first enabled digit; landing at
   // or below the starting index means the frame has wrapped.
   always_comb begin
      next_idx = idx;
      cand     = idx;
      found    = 1'b0;
      adv      = ADV_HOLD;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         cand = (cand == IDX_W'(NUM_DIGITS - 1)) ? '0 : cand + 1'b1;
         if (!found && digit_en[cand]) begin
            found    = 1'b1;
            next_idx = cand;
         end
      end
      if (found) adv = (next_idx <= idx) ? ADV_WRAP : ADV_STEP;
   end

   // A wrapping update already shows the freshly captured value.
   always_comb begin
      frame_data = (adv == ADV_WRAP) ? display : shadow;
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(next_idx) && frame_data[i*DIGIT_WIDTH +: DIGIT_WIDTH] != '0)
            upper_zero = 1'b0;
      end
      ctl_next = CTL_OFF;
      out_next = '0;
      if (adv != ADV_HOLD && digit_en[next_idx] &&
          !(lz_en && next_idx != '0 && upper_zero)) begin
         ctl_next = ~(NUM_DIGITS'(1) << next_idx);
         out_next = frame_data[next_idx*DIGIT_WIDTH +: DIGIT_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx        <= '0;
         shadow     <= '0;
         ctl        <= CTL_OFF;
         out        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            idx <= next_idx;
            ctl <= ctl_next;
            out <= out_next;
            if (adv == ADV_WRAP) begin
               shadow     <= display;
               frame_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_scan_ctl_n.sv
// Self-checking bench for scan_ctl_n: per-cycle reference model plus directed
// literal expectations for reset, scanning, masking, blanking and snapshots.
module tb_scan_ctl_n;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int SD = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*DW-1:0] display;
   logic [N-1:0]    digit_en;
   logic            lz_en;
   logic [N-1:0]    ctl;
   logic [DW-1:0]   out;
   logic            frame_done;

   int n_checks = 0;
   int n_pass   = 0;

   scan_ctl_n #(
      .NUM_DIGITS (N),
      .DIGIT_WIDTH(DW),
      .SCAN_DIV   (SD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .display   (display),
      .digit_en  (digit_en),
      .lz_en     (lz_en),
      .ctl       (ctl),
      .out       (out),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: what the display must show, derived from the scan rules.
   int       m_cnt;
   int       m_idx;
   int       m_shadow [N];
   bit [3:0] m_ctl;
   int       m_out;
   bit       m_fd;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cnt = 0;
         m_idx = 0;
         for (int i = 0; i < N; i++) m_shadow[i] = 0;
         m_ctl = 4'hF;
         m_out = 0;
         m_fd  = 0;
      end else begin
         m_fd = 0;
         if (m_cnt == SD - 1) begin
            m_cnt = 0;
            m_ctl = 4'hF;
            m_out = 0;
            if (digit_en != 0) begin
               int  nxt;
               bit  blank;
               nxt = m_idx;
               for (int k = N; k >= 1; k--)
                  if (digit_en[(m_idx + k) % N]) nxt = (m_idx + k) % N;
               if (nxt <= m_idx) begin
                  for (int i = 0; i < N; i++) m_shadow[i] = int'(display[i*DW +: DW]);
                  m_fd = 1;
               end
               m_idx = nxt;
               blank = 0;
               if (lz_en && m_idx != 0) begin
                  int sum;
                  sum = 0;
                  for (int i = m_idx; i < N; i++) sum += m_shadow[i];
                  blank = (sum == 0);
               end
               if (!blank) begin
                  m_ctl = 4'hF ^ (4'h1 << m_idx);
                  m_out = m_shadow[m_idx];
               end
            end
         end else begin
            m_cnt++;
         end
      end
      #1;
      n_checks++;
      if (ctl === m_ctl && out === DW'(m_out) && frame_done === m_fd) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL model t=%0t ctl=%b out=%0d fd=%b expected ctl=%b out=%0d fd=%b",
                  $time, ctl, out, frame_done, m_ctl, m_out, m_fd);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [N*DW-1:0] d, input logic [N-1:0] en,
                                 input logic lz);
      display  = d;
      digit_en = en;
      lz_en    = lz;
   endtask

   task automatic check_output(input string name, input logic [N-1:0] exp_ctl,
                               input logic [DW-1:0] exp_out, input logic exp_fd);
      n_checks++;
      if (ctl === exp_ctl && out === exp_out && frame_done === exp_fd) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got ctl=%b out=%0d fd=%b, expected ctl=%b out=%0d fd=%b",
                  name, ctl, out, frame_done, exp_ctl, exp_out, exp_fd);
      end
   endtask

   task automatic wait_frame_done(input string name);
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (frame_done !== 1'b1 && n < 200);
      if (frame_done !== 1'b1) begin
         n_checks++;
         $display("[TB] FAIL %s: frame_done timeout, got 0 expected 1", name);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      apply_stimulus(16'h4321, 4'b1111, 1'b0);
      step(3);
      check_output("reset_hold", 4'b1111, 4'd0, 1'b0);
      rst_n = 1'b1;

      step(3);
      check_output("pre_first_tick", 4'b1111, 4'd0, 1'b0);
      step(1);
      check_output("first_tick", 4'b1101, 4'd0, 1'b0);
      step(12);
      check_output("scan_wrap_d0", 4'b1110, 4'd1, 1'b1);
      step(1);
      check_output("fd_one_cycle", 4'b1110, 4'd1, 1'b0);
      step(3);
      check_output("scan_d1", 4'b1101, 4'd2, 1'b0);
      step(8);
      check_output("scan_d3", 4'b0111, 4'd4, 1'b0);

      apply_stimulus(16'h0907, 4'b0101, 1'b0);
      wait_frame_done("mask_sync");
      check_output("mask_d0", 4'b1110, 4'd7, 1'b1);
      step(4);
      check_output("mask_d2", 4'b1011, 4'd9, 1'b0);
      step(4);
      check_output("mask_wrap8", 4'b1110, 4'd7, 1'b1);

      apply_stimulus(16'h0050, 4'b1111, 1'b1);
      wait_frame_done("lz_sync");
      check_output("lz_d0", 4'b1110, 4'd0, 1'b1);
      step(4);
      check_output("lz_d1", 4'b1101, 4'd5, 1'b0);
      step(4);
      check_output("lz_d2_blank", 4'b1111, 4'd0, 1'b0);
      step(4);
      check_output("lz_d3_blank", 4'b1111, 4'd0, 1'b0);
      apply_stimulus(16'h0000, 4'b1111, 1'b1);
      wait_frame_done("lz0_sync");
      check_output("lz0_d0_lit", 4'b1110, 4'd0, 1'b1);
      step(4);
      check_output("lz0_d1_blank", 4'b1111, 4'd0, 1'b0);

      apply_stimulus(16'h1111, 4'b1111, 1'b0);
      wait_frame_done("snap_sync");
      check_output("snap_d0", 4'b1110, 4'd1, 1'b1);
      step(8);
      check_output("snap_d2", 4'b1011, 4'd1, 1'b0);
      apply_stimulus(16'h2222, 4'b1111, 1'b0);
      step(4);
      check_output("snap_d3_old", 4'b0111, 4'd1, 1'b0);
      wait_frame_done("snap_new_sync");
      check_output("snap_new", 4'b1110, 4'd2, 1'b1);

      apply_stimulus(16'h2222, 4'b0000, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(1);
         n_checks++;
         if (frame_done === 1'b0) n_pass++;
         else $display("[TB] FAIL alloff_no_fd: got fd=%b expected 0", frame_done);
      end
      check_output("alloff_dark", 4'b1111, 4'd0, 1'b0);
      apply_stimulus(16'h2222, 4'b1000, 1'b0);
      step(4);
      check_output("recover_d3", 4'b0111, 4'd2, 1'b0);
      step(4);
      check_output("single_wrap1", 4'b0111, 4'd2, 1'b1);
      step(4);
      check_output("single_wrap2", 4'b0111, 4'd2, 1'b1);

      step(2);
      rst_n = 1'b0;
      step(1);
      check_output("midscan_reset", 4'b1111, 4'd0, 1'b0);
      rst_n = 1'b1;
      step(4);
      check_output("post_reset_tick", 4'b0111, 4'd0, 1'b0);

      step(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
